// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

    // Receive state machine; advances only on filtered PS/2 clock falls.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS = 8;
    localparam int BIT_CNT_W     = $clog2(PS2_DATA_BITS);

    // Wide enough for FILTER_LEN up to 15.
    localparam int FILT_CNT_W    = 4;

    // Wide enough for TIMEOUT_CYCLES up to 65535.
    localparam int TO_CNT_W      = 16;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO: o_data is the head entry whenever o_empty is low.
module ps2_rx_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
    // Pop only when something is stored; a full FIFO accepts a push if it is popped in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisation and deglitching, frame
// deserialisation with parity/stop checks, timeout, host inhibit and byte FIFO.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2048,
    parameter int unsigned DEPTH_LOG2     = 2
) (
    input  logic                     clk_core,
    input  logic                     reset,
    input  logic                     ps2_clk_in,
    input  logic                     ps2_data_in,
    input  logic                     inhibit_req,
    output logic                     ps2_clk_oe,
    input  logic                     rd,
    output logic [PS2_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     frame_err,
    output logic                     overflow,
    input  logic                     err_clr
);

    // Input path registers (idle bus level is 1).
    logic                  r_clk_s1, r_clk_s2, r_clk_f, r_clk_prev;
    logic                  r_data_s1, r_data_s2, r_data_f;
    logic [FILT_CNT_W-1:0] r_clk_cnt, r_data_cnt;

    // Receive FSM and datapath registers.
    ps2_state_t               r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [PS2_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                     r_parity, w_parity_nxt;
    logic [TO_CNT_W-1:0]      r_to_cnt;
    logic                     r_push, w_push_nxt;
    logic [PS2_DATA_BITS-1:0] r_push_data;
    logic                     r_clk_oe;
    logic                     r_frame_err, r_overflow;

    logic w_fall;
    logic w_timeout;
    logic w_err_set;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign w_fall    = r_clk_prev & ~r_clk_f;
    assign w_timeout = (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES));

    // Two-flop synchronisers followed by counter filters on both pins.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_f    <= 1'b1;
            r_clk_prev <= 1'b1;
            r_clk_cnt  <= '0;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
            r_data_f   <= 1'b1;
            r_data_cnt <= '0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_f;
            r_data_s1  <= ps2_data_in;
            r_data_s2  <= r_data_s1;
            if (r_clk_s2 != r_clk_f) begin
                if (r_clk_cnt == FILT_CNT_W'(FILTER_LEN - 1)) begin
                    r_clk_f   <= r_clk_s2;
                    r_clk_cnt <= '0;
                end else begin
                    r_clk_cnt <= r_clk_cnt + FILT_CNT_W'(1);
                end
            end else begin
                r_clk_cnt <= '0;
            end
            if (r_data_s2 != r_data_f) begin
                if (r_data_cnt == FILT_CNT_W'(FILTER_LEN - 1)) begin
                    r_data_f   <= r_data_s2;
                    r_data_cnt <= '0;
                end else begin
                    r_data_cnt <= r_data_cnt + FILT_CNT_W'(1);
                end
            end else begin
                r_data_cnt <= '0;
            end
        end
    end

    // FSM state, shift register, timeout counter and registered FIFO push.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_clk_oe    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_parity    <= w_parity_nxt;
            r_push      <= w_push_nxt;
            r_push_data <= r_shift;
            r_clk_oe    <= inhibit_req;
            if (w_fall || (r_state == ST_IDLE)) begin
                r_to_cnt <= '0;
            end else if (!w_timeout) begin
                r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
            end
        end
    end

    // Next-state logic: inhibit overrides timeout, which overrides clock falls.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_push_nxt    = 1'b0;
        w_err_set     = 1'b0;
        if (r_clk_oe) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
        end else if ((r_state != ST_IDLE) && w_timeout) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_err_set     = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_data_f) begin
                        w_state_nxt   = ST_DATA;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt = {r_data_f, r_shift[PS2_DATA_BITS-1:1]};
                    if (r_bit_cnt == BIT_CNT_W'(PS2_DATA_BITS - 1)) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    w_parity_nxt = r_data_f;
                    w_state_nxt  = ST_STOP;
                end
                ST_STOP: begin
                    if (r_data_f && (^{r_shift, r_parity})) begin
                        w_push_nxt = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_drop = r_push & w_full & ~(rd & ~w_empty);

    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_err_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    ps2_rx_fifo #(
        .WIDTH      (PS2_DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk_core),
        .rst     (reset),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (rd),
        .o_data  (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ps2_clk_oe = r_clk_oe;
    assign rx_valid   = ~w_empty;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames driven on the pins with hand-computed expectations.
module tb_ps2_rx;

    logic       clk_core;
    logic       reset;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       inhibit_req;
    logic       ps2_clk_oe;
    logic       rd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic       err_clr;

    int total = 0;
    int bad   = 0;

    ps2_rx #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (2048),
        .DEPTH_LOG2     (2)
    ) dut (
        .clk_core    (clk_core),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .inhibit_req (inhibit_req),
        .ps2_clk_oe  (ps2_clk_oe),
        .rd          (rd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .err_clr     (err_clr)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives the first nbits of a frame; with do_lat, checks flag/valid timing after the stop-bit fall.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit glitch,
                              input int nbits, input bit do_lat, input bit exp_err,
                              input bit exp_val);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_in = fr[i];
            if (glitch) begin
                cyc(10); ps2_clk_in = 1'b0; cyc(1); ps2_clk_in = 1'b1; cyc(9);
            end else begin
                cyc(20);
            end
            ps2_clk_in = 1'b0;
            if (do_lat && i == 10) begin
                cyc(6);
                check("lat_valid_early", rx_valid, 8'd0);
                check("lat_err_early", frame_err, 8'd0);
                cyc(1);
                check("lat_err", frame_err, 8'(exp_err));
                check("lat_valid_7", rx_valid, 8'd0);
                cyc(1);
                check("lat_valid", rx_valid, 8'(exp_val));
                cyc(32);
            end else if (glitch) begin
                cyc(15); ps2_clk_in = 1'b1; cyc(1); ps2_clk_in = 1'b0; cyc(24);
            end else begin
                cyc(40);
            end
            ps2_clk_in = 1'b1;
            cyc(20);
        end
    endtask

    task automatic pop();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        inhibit_req = 1'b0;
        rd          = 1'b0;
        err_clr     = 1'b0;
        cyc(3);
        check("rst_oe", ps2_clk_oe, 8'd0);
        check("rst_valid", rx_valid, 8'd0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_err, 8'd0);
        check("rst_ovf", overflow, 8'd0);
        reset = 1'b0;
        cyc(10);
        check("idle_ferr", frame_err, 8'd0);

        // Good frame 0x1C with latency checks, then pop.
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b1);
        check("f1_valid", rx_valid, 8'd1);
        check("f1_data", rx_data, 8'h1C);
        check("f1_ferr", frame_err, 8'd0);
        check("f1_ovf", overflow, 8'd0);
        pop();
        check("f1_pop_valid", rx_valid, 8'd0);

        // Same frame with wrong parity: error, nothing queued.
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b1, 1'b1, 1'b0);
        check("par_ferr", frame_err, 8'd1);
        check("par_valid", rx_valid, 8'd0);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        check("par_clr", frame_err, 8'd0);

        // One-cycle glitches on the clock pin in every phase.
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0);
        check("gl_valid", rx_valid, 8'd1);
        check("gl_data", rx_data, 8'h5A);
        check("gl_ferr", frame_err, 8'd0);
        pop();

        // Five frames into a four-entry FIFO.
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        end
        check("ovf_set", overflow, 8'd1);
        check("ovf_ferr", frame_err, 8'd0);
        for (int b = 1; b <= 4; b++) begin
            check("ovf_valid", rx_valid, 8'd1);
            check("ovf_data", rx_data, 8'(b));
            pop();
        end
        check("ovf_empty", rx_valid, 8'd0);
        pop();
        check("pop_empty_ignored", rx_valid, 8'd0);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        check("ovf_clr", overflow, 8'd0);

        // Clock stops after the fourth data bit; timeout 2056 cycles after that pin fall.
        send_frame(8'hFF, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        cyc(1995);
        check("to_before", frame_err, 8'd0);
        cyc(1);
        check("to_after", frame_err, 8'd1);
        check("to_valid", rx_valid, 8'd0);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        send_frame(8'hAA, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        check("to_next_valid", rx_valid, 8'd1);
        check("to_next_data", rx_data, 8'hAA);
        check("to_next_ferr", frame_err, 8'd0);
        pop();

        // Host inhibit mid-frame.
        send_frame(8'h99, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        inhibit_req = 1'b1;
        cyc(1);
        check("inh_oe", ps2_clk_oe, 8'd1);
        ps2_clk_in = 1'b0;
        cyc(30);
        check("inh_ferr", frame_err, 8'd0);
        ps2_clk_in  = 1'b1;
        inhibit_req = 1'b0;
        cyc(1);
        check("inh_oe_rel", ps2_clk_oe, 8'd0);
        cyc(20);
        check("inh_ferr_rel", frame_err, 8'd0);
        check("inh_valid", rx_valid, 8'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        check("inh_next_data", rx_data, 8'h3C);
        check("inh_next_ferr", frame_err, 8'd0);
        pop();

        // Reset mid-frame with a queued byte and a raised error.
        send_frame(8'h11, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", rx_valid, 8'd1);
        check("pre_rst_ferr", frame_err, 8'd1);
        send_frame(8'h66, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(2);
        check("mrst_valid", rx_valid, 8'd0);
        check("mrst_data", rx_data, 8'h00);
        check("mrst_ferr", frame_err, 8'd0);
        check("mrst_ovf", overflow, 8'd0);
        check("mrst_oe", ps2_clk_oe, 8'd0);
        reset = 1'b0;
        cyc(5);
        send_frame(8'h42, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", rx_valid, 8'd1);
        check("post_rst_data", rx_data, 8'h42);
        check("post_rst_ferr", frame_err, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
